// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the data_ram arbiter slice.
package data_ram_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {IDLE, LOCK1} arb_state_t;

  // Word index beyond the RAM; the byte offset bits are ignored.
  function automatic logic is_oob(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr >> 2) >= ADDR_W'(depth);
  endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// One requester port of the data_ram arbiter: request fields in, grant/response out.
interface data_ram_arbiter_if;
  import data_ram_pkg::*;

  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/data_ram_arbiter_rr_arb2.sv
// Two-way round-robin grant with an override that forces requester 1 to win.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_force1,
  output logic o_gnt0,
  output logic o_gnt1
);

  // 1: requester 1 won last, so requester 0 has priority on a tie.
  logic r_last1;

  always_comb begin
    o_gnt1 = i_req1 & (i_force1 | ~i_req0 | ~r_last1);
    o_gnt0 = i_req0 & ~o_gnt1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last1 <= 1'b1;
    end else if (o_gnt0 | o_gnt1) begin
      r_last1 <= o_gnt1;
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single-port data_ram between the CPU LSU (m0) and the debug/DMA loader (m1).
module data_ram_arbiter
  import data_ram_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic                clk,
  input  logic                rst,
  data_ram_arbiter_if.slave   io_m0,
  data_ram_arbiter_if.slave   io_m1,
  output logic                o_ram_we,
  output logic                o_ram_re,
  output logic [ADDR_W-1:0]   o_ram_a,
  output logic [DATA_W-1:0]   o_ram_wd,
  input  logic [DATA_W-1:0]   i_ram_rd
);

  localparam int unsigned CntW = $clog2(MAX_LOCK + 1);

  arb_state_t        r_state, w_state_nxt;
  logic [CntW-1:0]   r_lock_cnt, w_lock_cnt_nxt;
  logic [ADDR_W-1:0] r_ram_a;
  logic [DATA_W-1:0] r_ram_wd;
  logic              r_rvalid0, r_rvalid1, r_err0, r_err1;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;

  logic              w_req0, w_req1, w_gnt0, w_gnt1, w_any;
  logic              w_cnt_max, w_lock_hold, w_oob, w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_unused_lock;

  assign w_unused_lock = io_m0.lock;

  // No grant can be issued while reset is asserted, so nothing reaches the RAM.
  assign w_req0 = io_m0.req & ~rst;
  assign w_req1 = io_m1.req & ~rst;

  assign w_cnt_max   = (r_lock_cnt == CntW'(MAX_LOCK));
  assign w_lock_hold = (r_state == LOCK1) & w_req1 & io_m1.lock & ~(w_req0 & w_cnt_max);

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .i_req0   (w_req0),
    .i_req1   (w_req1),
    .i_force1 (w_lock_hold),
    .o_gnt0   (w_gnt0),
    .o_gnt1   (w_gnt1)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_gnt1 & io_m1.lock) begin
          w_state_nxt    = LOCK1;
          w_lock_cnt_nxt = CntW'(1);
        end
      end
      LOCK1: begin
        if (w_lock_hold) begin
          if (!w_cnt_max) w_lock_cnt_nxt = r_lock_cnt + 1'b1;
        end else begin
          w_state_nxt    = IDLE;
          w_lock_cnt_nxt = '0;
        end
      end
    endcase
  end

  always_comb begin
    w_any       = w_gnt0 | w_gnt1;
    w_sel_we    = w_gnt1 ? io_m1.we    : io_m0.we;
    w_sel_addr  = w_gnt1 ? io_m1.addr  : io_m0.addr;
    w_sel_wdata = w_gnt1 ? io_m1.wdata : io_m0.wdata;
    w_oob       = is_oob(w_sel_addr, DEPTH);
    o_ram_we    = w_any & w_sel_we & ~w_oob;
    o_ram_re    = w_any & ~w_sel_we & ~w_oob;
    // The RAM address/data bus keeps its last driven value between grants.
    o_ram_a     = w_any ? w_sel_addr  : r_ram_a;
    o_ram_wd    = w_any ? w_sel_wdata : r_ram_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lock_cnt <= '0;
      r_ram_a    <= '0;
      r_ram_wd   <= '0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      if (w_any) begin
        r_ram_a  <= w_sel_addr;
        r_ram_wd <= w_sel_wdata;
      end
      r_rvalid0 <= w_gnt0;
      r_rvalid1 <= w_gnt1;
      r_err0    <= w_gnt0 & w_oob;
      r_err1    <= w_gnt1 & w_oob;
      r_rdata0  <= (w_gnt0 & ~w_sel_we & ~w_oob) ? i_ram_rd : '0;
      r_rdata1  <= (w_gnt1 & ~w_sel_we & ~w_oob) ? i_ram_rd : '0;
    end
  end

  assign io_m0.gnt    = w_gnt0;
  assign io_m1.gnt    = w_gnt1;
  assign io_m0.rvalid = r_rvalid0;
  assign io_m1.rvalid = r_rvalid1;
  assign io_m0.rdata  = r_rdata0;
  assign io_m1.rdata  = r_rdata1;
  assign io_m0.err    = r_err0;
  assign io_m1.err    = r_err1;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: vector table, lock burst and reset-pulse sequences.
module tb_data_ram_arbiter;
  import data_ram_pkg::*;

  localparam int unsigned DEPTH    = 1024;
  localparam int unsigned MAX_LOCK = 16;
  localparam int          NV       = 17;

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1, we, re;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_we, ram_re;
  logic [31:0] ram_a, ram_wd, ram_rd;
  logic [31:0] mem    [DEPTH];
  logic [31:0] shadow [DEPTH];

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  resp_t q0[$];
  resp_t q1[$];
  vec_t  vec[NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_ram_arbiter_if m0_bus ();
  data_ram_arbiter_if m1_bus ();

  data_ram_arbiter #(
    .DEPTH    (DEPTH),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_m0    (m0_bus),
    .io_m1    (m1_bus),
    .o_ram_we (ram_we),
    .o_ram_re (ram_re),
    .o_ram_a  (ram_a),
    .o_ram_wd (ram_wd),
    .i_ram_rd (ram_rd)
  );

  // Behavioural data_ram: combinational read, write at the clock edge.
  assign ram_rd = mem[ram_a[11:2]];
  always @(posedge clk) if (ram_we) mem[ram_a[11:2]] <= ram_wd;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]    <= 32'(i + 1);
      shadow[i]  = 32'(i + 1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_resp(input int m, input logic we, input logic [31:0] addr,
                             input logic [31:0] wd);
    resp_t r;
    logic  oob;
    oob     = addr >= DEPTH * 4;
    r.due   = cyc + 1;
    r.err   = oob;
    r.rdata = (!we && !oob) ? shadow[addr[11:2]] : 32'h0;
    if (we && !oob) shadow[addr[11:2]] = wd;
    if (m == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  always @(negedge clk) begin : monitor
    resp_t r;
    if (m0_bus.rvalid) begin
      if (q0.size() == 0) check("m0 unexpected rvalid", 32'd1, 32'd0);
      else begin
        r = q0.pop_front();
        check("m0 latency", cyc, r.due);
        check("m0 rdata", m0_bus.rdata, r.rdata);
        check("m0 err", m0_bus.err, r.err);
      end
    end
    if (m1_bus.rvalid) begin
      if (q1.size() == 0) check("m1 unexpected rvalid", 32'd1, 32'd0);
      else begin
        r = q1.pop_front();
        check("m1 latency", cyc, r.due);
        check("m1 rdata", m1_bus.rdata, r.rdata);
        check("m1 err", m1_bus.err, r.err);
      end
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1, input logic l1);
    m0_bus.req = r0; m0_bus.we = w0; m0_bus.addr = a0; m0_bus.wdata = d0; m0_bus.lock = 1'b0;
    m1_bus.req = r1; m1_bus.we = w1; m1_bus.addr = a1; m1_bus.wdata = d1; m1_bus.lock = l1;
  endtask

  function automatic vec_t mk(input logic r0, input logic w0, input logic [31:0] a0,
                              input logic [31:0] d0, input logic r1, input logic w1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic g0, input logic g1, input logic we, input logic re);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.we = we; v.re = re;
    return v;
  endfunction

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int   k1;
  logic m0_done;

  initial begin
    // Reset leaves m0 first in line; after row 2 m0 was last, so both-request rows start with m1.
    vec[0]  = mk(1, 0, 32'h0,    0,         0, 0, 0,        0,          1, 0, 0, 1);
    vec[1]  = mk(0, 0, 0,        0,         1, 1, 32'h100,  32'hDEAD,   0, 1, 1, 0);
    vec[2]  = mk(1, 0, 32'h100,  0,         0, 0, 0,        0,          1, 0, 0, 1);
    for (int k = 0; k < 8; k++)
      vec[3+k] = mk(1, 0, 32'h8, 0, 1, 0, 32'hC, 0, k[0], ~k[0], 0, 1);
    vec[11] = mk(1, 1, 32'h1000, 32'hBAD,   0, 0, 0,        0,          1, 0, 0, 0);
    vec[12] = mk(0, 0, 0,        0,         1, 1, 32'hFFC,  32'h1234,   0, 1, 1, 0);
    vec[13] = mk(0, 0, 0,        0,         1, 0, 32'hFFC,  0,          0, 1, 0, 1);
    vec[14] = mk(0, 0, 0,        0,         0, 0, 0,        0,          0, 0, 0, 0);
    vec[15] = mk(1, 0, 32'h1004, 0,         1, 0, 32'h4,    0,          1, 0, 0, 0);
    vec[16] = mk(0, 0, 0,        0,         1, 1, 32'h8,    32'h55AA,   0, 1, 1, 0);

    rst = 1'b1;
    drive(1, 0, 32'h0, 0, 1, 1, 32'h20, 32'h77, 1);
    @(negedge clk);
    check("reset gnt0", m0_bus.gnt, 0);
    check("reset gnt1", m1_bus.gnt, 0);
    check("reset rvalid0", m0_bus.rvalid, 0);
    check("reset rvalid1", m1_bus.rvalid, 0);
    check("reset ram_we", ram_we, 0);
    check("reset ram_re", ram_re, 0);
    check("reset ram_a", ram_a, 0);
    check("reset ram_wd", ram_wd, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].r0, vec[i].w0, vec[i].a0, vec[i].d0,
            vec[i].r1, vec[i].w1, vec[i].a1, vec[i].d1, 0);
      @(negedge clk);
      check($sformatf("vec%0d gnt0", i), m0_bus.gnt, vec[i].g0);
      check($sformatf("vec%0d gnt1", i), m1_bus.gnt, vec[i].g1);
      check($sformatf("vec%0d ram_we", i), ram_we, vec[i].we);
      check($sformatf("vec%0d ram_re", i), ram_re, vec[i].re);
      if (vec[i].g0) expect_resp(0, vec[i].w0, vec[i].a0, vec[i].d0);
      if (vec[i].g1) expect_resp(1, vec[i].w1, vec[i].a1, vec[i].d1);
      @(posedge clk); #1;
    end
    idle(2);
    check("oob write left RAM alone", mem[0], 32'h1);
    check("in-range write landed", mem[2], 32'h55AA);

    // m1 burst under lock; m0 joins at cycle 2 and must wait MAX_LOCK grants.
    k1      = 0;
    m0_done = 1'b0;
    for (int c = 0; c < 21; c++) begin
      drive((c >= 2) && !m0_done, 0, 32'h10, 0, k1 < 20, 0, 32'h400 + 32'(k1 * 4), 0, 1);
      @(negedge clk);
      check($sformatf("lock c%0d gnt0", c), m0_bus.gnt, 32'(c == 16));
      check($sformatf("lock c%0d gnt1", c), m1_bus.gnt, 32'(c != 16));
      if (m0_bus.gnt) begin
        expect_resp(0, 0, 32'h10, 0);
        m0_done = 1'b1;
      end
      if (m1_bus.gnt) begin
        expect_resp(1, 0, 32'h400 + 32'(k1 * 4), 0);
        k1++;
      end
      @(posedge clk); #1;
    end
    check("burst words", k1, 20);
    idle(2);

    // Enter LOCK1, then reset in the middle of a granted m1 write.
    drive(0, 0, 0, 0, 1, 0, 32'h0, 0, 1);
    @(negedge clk);
    check("pre-rst gnt1", m1_bus.gnt, 1);
    expect_resp(1, 0, 32'h0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 1, 32'h300, 32'hBEEF, 1);
    @(negedge clk);
    check("rst-write gnt1", m1_bus.gnt, 1);
    check("rst-write ram_we", ram_we, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid-rst gnt1", m1_bus.gnt, 0);
    check("mid-rst ram_we", ram_we, 0);
    check("mid-rst ram_a", ram_a, 0);
    check("mid-rst ram_wd", ram_wd, 0);
    check("mid-rst rvalid1", m1_bus.rvalid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("post-rst rvalid1", m1_bus.rvalid, 0);
    rst = 1'b0;

    drive(1, 0, 32'h4, 0, 1, 0, 32'h8, 0, 1);
    @(negedge clk);
    check("after rst gnt0", m0_bus.gnt, 1);
    check("after rst gnt1", m1_bus.gnt, 0);
    if (m0_bus.gnt) expect_resp(0, 0, 32'h4, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 0, 32'h8, 0, 1);
    @(negedge clk);
    check("after rst m1 gnt", m1_bus.gnt, 1);
    if (m1_bus.gnt) expect_resp(1, 0, 32'h8, 0);
    @(posedge clk); #1;
    idle(3);
    check("aborted write not in RAM", mem[192], 32'd193);
    check("m0 responses drained", q0.size(), 0);
    check("m1 responses drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
